// File: rtl/write_merge_buffer.sv
// rtl/write_merge_buffer.sv - single-line byte-masked write-combining buffer with flush handshake
module write_merge_buffer #(
    parameter int ADDR_W     = 16,
    parameter int WORD_BYTES = 2,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_req,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [8*WORD_BYTES-1:0] wr_data,
    input  logic [WORD_BYTES-1:0]   wr_be,
    output logic                    wr_ack,
    input  logic                    flush_now,
    output logic                    flush_valid,
    input  logic                    flush_ack,
    output logic [ADDR_W-1:0]       flush_addr,
    output logic [8*LINE_BYTES-1:0] flush_line,
    output logic [LINE_BYTES-1:0]   flush_mask,
    output logic                    idle
);
    localparam int BSEL_W = $clog2(WORD_BYTES);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int WSEL_W = OFF_W - BSEL_W;
    localparam int TAG_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;

    state_t                  state, state_next;
    logic [TAG_W-1:0]        tag;
    logic [8*LINE_BYTES-1:0] line, merged_line;
    logic [LINE_BYTES-1:0]   mask, merged_mask;
    logic [TAG_W-1:0]        wr_tag;
    logic [WSEL_W-1:0]       wr_wsel;
    logic [OFF_W-1:0]        byte_idx;
    logic                    tag_hit, accept, do_merge;
    logic                    unused_addr_bits;

    assign wr_tag           = wr_addr[ADDR_W-1:OFF_W];
    assign wr_wsel          = wr_addr[OFF_W-1:BSEL_W];
    assign unused_addr_bits = ^(wr_addr & ADDR_W'(WORD_BYTES-1));
    assign tag_hit          = (wr_tag == tag);

    // A request still high during its own ack cycle must not be merged twice.
    assign accept   = wr_req && !wr_ack &&
                      ((state == EMPTY) || (state == HOLD && tag_hit && !flush_now));
    assign do_merge = accept && (|wr_be);

    always_comb begin
        merged_line = line;
        merged_mask = mask;
        byte_idx    = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            byte_idx = (OFF_W'(wr_wsel) << BSEL_W) + OFF_W'(i);
            if (wr_be[i]) begin
                merged_line[{byte_idx, 3'b000} +: 8] = wr_data[8*i +: 8];
                merged_mask[byte_idx]                = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (do_merge) state_next = HOLD;
            HOLD: begin
                // Flush wins over a concurrent write; a conflicting write waits for the drain.
                if (flush_now || (wr_req && !tag_hit))
                    state_next = FLUSH;
                else if (do_merge && (&merged_mask))
                    state_next = FLUSH;
            end
            FLUSH: if (flush_ack) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            tag    <= '0;
            line   <= '0;
            mask   <= '0;
            wr_ack <= 1'b0;
        end else begin
            state  <= state_next;
            wr_ack <= accept;
            if (do_merge) begin
                line <= merged_line;
                mask <= merged_mask;
            end
            if (state == EMPTY && do_merge)
                tag <= wr_tag;
            if (state == FLUSH && flush_ack)
                mask <= '0;
        end
    end

    assign flush_valid = (state == FLUSH);
    assign idle        = (state == EMPTY);
    assign flush_addr  = {tag, OFF_W'(0)};
    assign flush_mask  = mask;

    for (genvar b = 0; b < LINE_BYTES; b++) begin : g_zero
        assign flush_line[8*b +: 8] = mask[b] ? line[8*b +: 8] : 8'h00;
    end

endmodule

// File: doc/write_merge_buffer.md
Name: write_merge_buffer

Overview:
- Single-line write-combining buffer between the CPU-side data port and the L1/L2 write path.
- Accepts byte-enabled word writes, merges them into one buffered line, and tracks a per-byte valid mask.
- Issues a whole-line flush (line, mask, line address) downstream on line conflict, on an explicit flush request, or when the line becomes fully written.
- Parametrised successor to the fixed 256-bit / 16-bit byte-merge logic; adds storage, masking and a flush handshake.

Parameters:
ADDR_W, 16, byte-address width
WORD_BYTES, 2, bytes per CPU write word (power of 2, ≥1)
LINE_BYTES, 32, bytes per line (power of 2, > WORD_BYTES)
Derived (localparam): OFF_W = log2(LINE_BYTES), WSEL_W = OFF_W - log2(WORD_BYTES), TAG_W = ADDR_W - OFF_W

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wr_req  in  1  write request; held stable until wr_ack
wr_addr  in  ADDR_W  byte address; the low log2(WORD_BYTES) bits are ignored
wr_data  in  8*WORD_BYTES  write data, byte i = bits [8i+7:8i]
wr_be  in  WORD_BYTES  byte enables
wr_ack  out  1  one-cycle pulse, write merged
flush_now  in  1  request flush of the held line (level, sampled each cycle)
flush_valid  out  1  flush payload valid; held until flush_ack
flush_ack  in  1  downstream accepted the flush
flush_addr  out  ADDR_W  line base address ({tag, OFF_W zeros})
flush_line  out  8*LINE_BYTES  line data; bytes with mask bit 0 read as 0x00
flush_mask  out  LINE_BYTES  per-byte valid mask
idle  out  1  high in EMPTY

Behaviour:
- States: EMPTY, HOLD, FLUSH.
- Reset: state=EMPTY, mask=0, line=0, tag=0, wr_ack=0, flush_valid=0, idle=1. Reset in any state, including mid-FLUSH, drops flush_valid the next cycle and discards the line.
- Accept condition: wr_req && !wr_ack && state≠FLUSH && !(state==HOLD && (tag mismatch || flush_now)). wr_ack is registered and asserts the cycle after acceptance. A request held during its ack cycle is not re-accepted, so the earliest back-to-back acceptance is every 2 cycles.
- Merge on accept: word slot w = wr_addr[OFF_W-1:log2(WORD_BYTES)]. For each i with wr_be[i]=1, line byte (w*WORD_BYTES+i) = wr_data byte i and its mask bit is set. Other bytes are unchanged; a later write to a byte overwrites it.
- EMPTY:
  - Accepted with wr_be≠0 → tag=wr_addr[ADDR_W-1:OFF_W], merge, go to HOLD.
  - Accepted with wr_be=0 → acked, no state change.
  - flush_now is ignored.
- HOLD:
  - flush_now=1 → FLUSH; a concurrent wr_req is not accepted (flush wins).
  - wr_req with tag mismatch → FLUSH; the request stays pending and is accepted after the line drains.
  - Tag match → merge and ack. If the resulting mask is all ones → FLUSH next cycle (auto-flush); otherwise remain in HOLD.
- FLUSH:
  - flush_valid=1; flush_addr, line and mask are stable.
  - On flush_ack → EMPTY, mask cleared, flush_valid=0 next cycle.
  - wr_req is never accepted in FLUSH.
  - flush_ack outside FLUSH is ignored.
- Latency: hit write acks after 1 cycle. A conflicting write acks no earlier than 2 cycles after flush_ack (1 cycle to drain to EMPTY, 1 to accept).
- flush_line zeroing of unmasked bytes is combinational from the mask.

Test Plan:
1. Write 0x0104 data 0xBEEF be=11 from EMPTY → wr_ack next cycle, idle=0. Then flush_now → flush_valid, flush_addr=0x0100, flush_mask=0x00000030, line bytes 4/5 = EF/BE, all other bytes 0. flush_ack → idle=1.
2. Write 0x0100 data 0x12AB be=01, then 0x0101 data 0xCD34 be=10 → merged bytes 0/1 = AB/CD, mask=0x00000003 (the addr LSB is ignored).
3. Conflict: hold 0x0100 (be=11, 0x1111), write 0x0220 → flush of 0x0100 with mask=0x3. Downstream delays flush_ack 3 cycles; the pending write is not acked until after flush_ack, then acked. Next flush shows addr=0x0220, mask=0x3.
4. Write all 16 words of 0x0300 (data = word index) → auto-flush after the 16th ack, mask=0xFFFFFFFF, no flush_now needed.
5. Assert rst during FLUSH with flush_ack low → next cycle flush_valid=0, idle=1, mask=0. A subsequent flush_now in EMPTY produces no flush.
6. In EMPTY, write be=00 → wr_ack pulses, idle stays 1. In HOLD, flush_now and matching wr_req in the same cycle → no ack, FLUSH entered, write accepted after the drain.
